vend_controller: RTL and testbench
==================================

Name: vend_controller

Overview:
Sequencing FSM for the vending machine. Accepts 5- and 10-unit coins, accumulates credit and, on a product select (price 10/15/20), issues a one-cycle dispense pulse. It then pays change one coin per cycle on the c1 (5-unit) and c2 (10-unit) strobes. Cancel refunds all credit. The block owns the sequencing; its z/c1/c2 strobes feed the existing product/change result outputs.

Parameters:
PRICE_A, 10, price of product A (sel=2'b01), money units, multiple of 5
PRICE_B, 15, price of product B (sel=2'b10)
PRICE_C, 20, price of product C (sel=2'b11)
MAX_CREDIT, 30, credit ceiling; a coin that would exceed it is rejected
CREDIT_W, 6, credit register width; must hold MAX_CREDIT

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
coin5  input  1  one-cycle pulse: 5-unit coin inserted
coin10  input  1  one-cycle pulse: 10-unit coin inserted
sel  input  2  product select pulse; 2'b00 = none
cancel  input  1  one-cycle pulse: refund all credit
z  output  1  dispense strobe, one cycle per vend
c1  output  1  return one 5-unit coin, one cycle per coin
c2  output  1  return one 10-unit coin, one cycle per coin
coin_rej  output  1  registered: coin from the previous cycle was rejected
busy  output  1  high in DISPENSE or CHANGE
credit  output  CREDIT_W  current credit, for display

Behaviour:
- States: IDLE (credit==0), COLLECT (credit>0), DISPENSE, CHANGE. All inputs are sampled on the rising clk edge.
- Reset: state=IDLE, credit=0, z=c1=c2=coin_rej=busy=0. This applies from any state, including mid-CHANGE; unpaid change is discarded.
- Priority in IDLE/COLLECT, per cycle: cancel > sel > coin.
- cancel with credit>0 -> CHANGE. With credit==0, cancel is a no-op. A coin in the same cycle as cancel is rejected.
- sel!=0 with credit>=price(sel): credit -= price and go to DISPENSE. A coin in the same cycle is rejected.
- sel!=0 with credit<price: sel is ignored and the coin rules apply.
- Coin accept: credit += value; IDLE->COLLECT.
- Coin reject: coin5&coin10 both high, credit+value>MAX_CREDIT, or the state is DISPENSE/CHANGE. A rejected coin leaves credit unchanged and sets coin_rej=1 for the next cycle.
- DISPENSE: exactly one cycle, z=1. Next state is CHANGE if credit>0, else IDLE.
- CHANGE: one coin per cycle.
  - credit>=10: c2=1, credit -= 10.
  - credit==5: c1=1, credit -= 5.
  - credit==0 after the subtraction: next state is IDLE.
  - sel and cancel are ignored.
- Latency: sel accepted at edge N gives z high in cycle N+1. The first change coin appears in cycle N+2. Cancel at edge N gives the first coin in cycle N+1.
- z, c1, c2, busy are decoded from state/credit registers only; there is no combinational input-to-output path. z, c1, c2 are mutually exclusive.
- Credit never exceeds MAX_CREDIT, never underflows, and stays a multiple of 5.

Decomposition:
- Shared package vend_pkg holds:
  - state encoding (IDLE/COLLECT/DISPENSE/CHANGE)
  - sel codes SEL_NONE/SEL_A/SEL_B/SEL_C
  - coin values COIN5=5, COIN10=10
  - default prices
- One sub-module, vend_price_lut: combinational sel -> price decode plus a credit>=price compare. It is instantiated once.

Test Plan:
- Reset, then coin10, coin10, sel=C(20) -> credit 10, then 20; z=1 in cycle N+1; no c1/c2; IDLE; busy low.
- coin10 x3 (credit 30), sel=B(15) -> z in N+1; c2 in N+2; c1 in N+3; credit 0; IDLE in N+4.
- Credit 25, coin10 -> coin_rej=1 next cycle, credit stays 25. coin5&coin10 together -> rejected, credit unchanged.
- Credit 25, cancel -> c2, c2, c1 on three consecutive cycles; credit 25->15->5->0; sel=A and coin5 during CHANGE are ignored/rejected.
- Credit 5, sel=A -> no z, stays COLLECT. Same cycle as a coin5: the coin is accepted, credit=10.
- rst asserted mid-CHANGE (credit 20) -> next cycle credit=0, c1=c2=0, IDLE. sel and coin10 in the same cycle as cancel: cancel wins, coin rejected.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types and constants for the vending controller.
// Holds state encoding, select codes, coin values and default prices.
package vend_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_COLLECT  = 2'd1,
    S_DISPENSE = 2'd2,
    S_CHANGE   = 2'd3
  } state_t;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_A    = 2'b01;
  localparam logic [1:0] SEL_B    = 2'b10;
  localparam logic [1:0] SEL_C    = 2'b11;

  localparam int COIN5  = 5;
  localparam int COIN10 = 10;

  localparam int DEF_PRICE_A    = 10;
  localparam int DEF_PRICE_B    = 15;
  localparam int DEF_PRICE_C    = 20;
  localparam int DEF_MAX_CREDIT = 30;
  localparam int DEF_CREDIT_W   = 6;

endpackage

// File: rtl/vend_if.sv
// Customer-side bus of the vending controller.
// master: coin5/coin10/sel/cancel out; slave: z/c1/c2/coin_rej/busy/credit out.
interface vend_if #(
  parameter int CREDIT_W = 6
);

  logic                coin5;
  logic                coin10;
  logic [1:0]          sel;
  logic                cancel;
  logic                z;
  logic                c1;
  logic                c2;
  logic                coin_rej;
  logic                busy;
  logic [CREDIT_W-1:0] credit;

  modport master (
    output coin5, coin10, sel, cancel,
    input  z, c1, c2, coin_rej, busy, credit
  );

  modport slave (
    input  coin5, coin10, sel, cancel,
    output z, c1, c2, coin_rej, busy, credit
  );

endinterface

// File: rtl/vend_price_lut.sv
// Select-to-price decode and affordability compare.
// Ports: sel, credit in; price, afford (sel valid and credit>=price) out.
import vend_pkg::*;

module vend_price_lut #(
  parameter int PRICE_A  = DEF_PRICE_A,
  parameter int PRICE_B  = DEF_PRICE_B,
  parameter int PRICE_C  = DEF_PRICE_C,
  parameter int CREDIT_W = DEF_CREDIT_W
) (
  input  logic [1:0]          sel,
  input  logic [CREDIT_W-1:0] credit,
  output logic [CREDIT_W-1:0] price,
  output logic                afford
);

  always_comb begin
    price = '0;
    unique case (sel)
      SEL_A:   price = CREDIT_W'(PRICE_A);
      SEL_B:   price = CREDIT_W'(PRICE_B);
      SEL_C:   price = CREDIT_W'(PRICE_C);
      default: price = '0;
    endcase
  end

  assign afford = (sel != SEL_NONE) && (credit >= price);

endmodule

// File: rtl/vend_controller.sv
// Vending sequencer: coin accumulation, vend strobe, coin-by-coin change.
// Ports: clk, rst (sync, active-high), bus (vend_if.slave).
import vend_pkg::*;

module vend_controller #(
  parameter int PRICE_A    = DEF_PRICE_A,
  parameter int PRICE_B    = DEF_PRICE_B,
  parameter int PRICE_C    = DEF_PRICE_C,
  parameter int MAX_CREDIT = DEF_MAX_CREDIT,
  parameter int CREDIT_W   = DEF_CREDIT_W
) (
  input logic   clk,
  input logic   rst,
  vend_if.slave bus
);

  localparam logic [CREDIT_W:0] MAX_W = (CREDIT_W+1)'(MAX_CREDIT);

  state_t              state, state_n;
  logic [CREDIT_W-1:0] credit, credit_n;
  logic                rej, rej_n;

  logic [CREDIT_W-1:0] price;
  logic                afford;
  logic                coin_any;
  logic                coin_bad;
  logic [CREDIT_W:0]   sum;
  logic [CREDIT_W-1:0] change_amt;

  vend_price_lut #(
    .PRICE_A  (PRICE_A),
    .PRICE_B  (PRICE_B),
    .PRICE_C  (PRICE_C),
    .CREDIT_W (CREDIT_W)
  ) u_lut (
    .sel    (bus.sel),
    .credit (credit),
    .price  (price),
    .afford (afford)
  );

  assign coin_any = bus.coin5 | bus.coin10;
  assign coin_bad = bus.coin5 & bus.coin10;
  assign sum = {1'b0, credit}
             + (bus.coin10 ? (CREDIT_W+1)'(COIN10)
                           : (CREDIT_W+1)'(COIN5));
  assign change_amt = (credit >= CREDIT_W'(COIN10))
                    ? CREDIT_W'(COIN10)
                    : CREDIT_W'(COIN5);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      credit <= '0;
      rej    <= 1'b0;
    end else begin
      state  <= state_n;
      credit <= credit_n;
      rej    <= rej_n;
    end
  end

  always_comb begin
    state_n  = state;
    credit_n = credit;
    rej_n    = 1'b0;
    unique case (state)
      S_IDLE, S_COLLECT: begin
        if (bus.cancel) begin
          // cancel outranks any coin, even a no-op cancel
          rej_n = coin_any;
          if (credit != '0) state_n = S_CHANGE;
        end else if (afford) begin
          rej_n    = coin_any;
          credit_n = credit - price;
          state_n  = S_DISPENSE;
        end else if (coin_any) begin
          if (coin_bad || sum > MAX_W) begin
            rej_n = 1'b1;
          end else begin
            credit_n = sum[CREDIT_W-1:0];
            state_n  = S_COLLECT;
          end
        end
      end
      S_DISPENSE: begin
        rej_n   = coin_any;
        state_n = (credit != '0) ? S_CHANGE : S_IDLE;
      end
      S_CHANGE: begin
        rej_n    = coin_any;
        credit_n = credit - change_amt;
        if (credit_n == '0) state_n = S_IDLE;
      end
      default: begin
        state_n  = S_IDLE;
        credit_n = '0;
      end
    endcase
  end

  // strobes come only from registers: no input-to-output path
  assign bus.z        = (state == S_DISPENSE);
  assign bus.c2       = (state == S_CHANGE)
                     && (credit >= CREDIT_W'(COIN10));
  assign bus.c1       = (state == S_CHANGE)
                     && (credit == CREDIT_W'(COIN5));
  assign bus.busy     = (state == S_DISPENSE)
                     || (state == S_CHANGE);
  assign bus.coin_rej = rej;
  assign bus.credit   = credit;

endmodule

// File: tb/tb_vend_controller.sv
// Directed self-checking bench for vend_controller.
// Inputs driven and outputs sampled 1 time unit after each rising edge.
module tb_vend_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  vend_if #(.CREDIT_W(6)) bus ();

  vend_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick(input logic c5, input logic c10,
                      input logic [1:0] s, input logic cn);
    bus.coin5  = c5;
    bus.coin10 = c10;
    bus.sel    = s;
    bus.cancel = cn;
    @(posedge clk);
    #1;
    bus.coin5  = 1'b0;
    bus.coin10 = 1'b0;
    bus.sel    = 2'b00;
    bus.cancel = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(0, 0, 2'b00, 0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if (bus.credit !== 6'd0) begin
      fails++;
      $display("FAIL reset_credit got %0d want 0", bus.credit);
    end
    tests++;
    if ({bus.z, bus.c1, bus.c2, bus.coin_rej, bus.busy} !== 5'b0) begin
      fails++;
      $display("FAIL reset_outs got %b want 00000",
               {bus.z, bus.c1, bus.c2, bus.coin_rej, bus.busy});
    end
  endtask

  task automatic test_vend_exact();
    do_reset();
    tick(0, 1, 2'b00, 0);
    tests++;
    if (bus.credit !== 6'd10) begin
      fails++;
      $display("FAIL exact_c1 got %0d want 10", bus.credit);
    end
    tick(0, 1, 2'b00, 0);
    tests++;
    if (bus.credit !== 6'd20) begin
      fails++;
      $display("FAIL exact_c2 got %0d want 20", bus.credit);
    end
    tick(0, 0, 2'b11, 0);
    tests++;
    if ({bus.z, bus.c1, bus.c2, bus.busy} !== 4'b1001
        || bus.credit !== 6'd0) begin
      fails++;
      $display("FAIL exact_vend z/c1/c2/busy %b want 1001 credit %0d want 0",
               {bus.z, bus.c1, bus.c2, bus.busy}, bus.credit);
    end
    tick(0, 0, 2'b00, 0);
    tests++;
    if ({bus.z, bus.c1, bus.c2, bus.busy} !== 4'b0000) begin
      fails++;
      $display("FAIL exact_idle z/c1/c2/busy %b want 0000",
               {bus.z, bus.c1, bus.c2, bus.busy});
    end
  endtask

  task automatic test_change();
    do_reset();
    for (int i = 0; i < 3; i++) tick(0, 1, 2'b00, 0);
    tests++;
    if (bus.credit !== 6'd30) begin
      fails++;
      $display("FAIL chg_fill got %0d want 30", bus.credit);
    end
    tick(0, 0, 2'b10, 0);
    tests++;
    if ({bus.z, bus.c1, bus.c2} !== 3'b100 || bus.credit !== 6'd15) begin
      fails++;
      $display("FAIL chg_z z/c1/c2 %b want 100 credit %0d want 15",
               {bus.z, bus.c1, bus.c2}, bus.credit);
    end
    tick(0, 0, 2'b00, 0);
    tests++;
    if ({bus.z, bus.c1, bus.c2} !== 3'b001 || bus.credit !== 6'd15) begin
      fails++;
      $display("FAIL chg_c2 z/c1/c2 %b want 001 credit %0d want 15",
               {bus.z, bus.c1, bus.c2}, bus.credit);
    end
    tick(0, 0, 2'b00, 0);
    tests++;
    if ({bus.z, bus.c1, bus.c2} !== 3'b010 || bus.credit !== 6'd5) begin
      fails++;
      $display("FAIL chg_c1 z/c1/c2 %b want 010 credit %0d want 5",
               {bus.z, bus.c1, bus.c2}, bus.credit);
    end
    tick(0, 0, 2'b00, 0);
    tests++;
    if ({bus.z, bus.c1, bus.c2, bus.busy} !== 4'b0000
        || bus.credit !== 6'd0) begin
      fails++;
      $display("FAIL chg_idle outs %b want 0000 credit %0d want 0",
               {bus.z, bus.c1, bus.c2, bus.busy}, bus.credit);
    end
  endtask

  task automatic test_reject();
    do_reset();
    tick(0, 1, 2'b00, 0);
    tick(0, 1, 2'b00, 0);
    tick(1, 0, 2'b00, 0);
    tests++;
    if (bus.credit !== 6'd25 || bus.coin_rej !== 1'b0) begin
      fails++;
      $display("FAIL rej_fill credit %0d want 25 rej %b want 0",
               bus.credit, bus.coin_rej);
    end
    tick(0, 1, 2'b00, 0);
    tests++;
    if (bus.credit !== 6'd25 || bus.coin_rej !== 1'b1) begin
      fails++;
      $display("FAIL rej_over credit %0d want 25 rej %b want 1",
               bus.credit, bus.coin_rej);
    end
    tick(0, 0, 2'b00, 0);
    tests++;
    if (bus.coin_rej !== 1'b0) begin
      fails++;
      $display("FAIL rej_clear got %b want 0", bus.coin_rej);
    end
    tick(1, 1, 2'b00, 0);
    tests++;
    if (bus.credit !== 6'd25 || bus.coin_rej !== 1'b1) begin
      fails++;
      $display("FAIL rej_both credit %0d want 25 rej %b want 1",
               bus.credit, bus.coin_rej);
    end
  endtask

  task automatic test_max();
    do_reset();
    tick(0, 1, 2'b00, 0);
    tick(0, 1, 2'b00, 0);
    tick(1, 0, 2'b00, 0);
    tick(1, 0, 2'b00, 0);
    tests++;
    if (bus.credit !== 6'd30 || bus.coin_rej !== 1'b0) begin
      fails++;
      $display("FAIL max_fill credit %0d want 30 rej %b want 0",
               bus.credit, bus.coin_rej);
    end
    tick(1, 0, 2'b00, 0);
    tests++;
    if (bus.credit !== 6'd30 || bus.coin_rej !== 1'b1) begin
      fails++;
      $display("FAIL max_over credit %0d want 30 rej %b want 1",
               bus.credit, bus.coin_rej);
    end
  endtask

  task automatic test_cancel();
    do_reset();
    tick(0, 1, 2'b00, 0);
    tick(0, 1, 2'b00, 0);
    tick(1, 0, 2'b00, 0);
    tick(0, 0, 2'b00, 1);
    tests++;
    if ({bus.c1, bus.c2, bus.busy} !== 3'b011 || bus.credit !== 6'd25) begin
      fails++;
      $display("FAIL cxl_1 c1/c2/busy %b want 011 credit %0d want 25",
               {bus.c1, bus.c2, bus.busy}, bus.credit);
    end
    tick(1, 0, 2'b01, 0);
    tests++;
    if ({bus.z, bus.c1, bus.c2, bus.coin_rej} !== 4'b0011
        || bus.credit !== 6'd15) begin
      fails++;
      $display("FAIL cxl_2 z/c1/c2/rej %b want 0011 credit %0d want 15",
               {bus.z, bus.c1, bus.c2, bus.coin_rej}, bus.credit);
    end
    tick(0, 0, 2'b00, 0);
    tests++;
    if ({bus.z, bus.c1, bus.c2} !== 3'b010 || bus.credit !== 6'd5) begin
      fails++;
      $display("FAIL cxl_3 z/c1/c2 %b want 010 credit %0d want 5",
               {bus.z, bus.c1, bus.c2}, bus.credit);
    end
    tick(0, 0, 2'b00, 0);
    tests++;
    if ({bus.c1, bus.c2, bus.busy} !== 3'b000 || bus.credit !== 6'd0) begin
      fails++;
      $display("FAIL cxl_end c1/c2/busy %b want 000 credit %0d want 0",
               {bus.c1, bus.c2, bus.busy}, bus.credit);
    end
  endtask

  task automatic test_insufficient();
    do_reset();
    tick(1, 0, 2'b00, 0);
    tick(0, 0, 2'b01, 0);
    tests++;
    if ({bus.z, bus.busy} !== 2'b00 || bus.credit !== 6'd5) begin
      fails++;
      $display("FAIL low_sel z/busy %b want 00 credit %0d want 5",
               {bus.z, bus.busy}, bus.credit);
    end
    tick(1, 0, 2'b01, 0);
    tests++;
    if ({bus.z, bus.coin_rej} !== 2'b00 || bus.credit !== 6'd10) begin
      fails++;
      $display("FAIL low_coin z/rej %b want 00 credit %0d want 10",
               {bus.z, bus.coin_rej}, bus.credit);
    end
  endtask

  task automatic test_reset_mid_change();
    do_reset();
    tick(0, 1, 2'b00, 0);
    tick(0, 1, 2'b00, 0);
    tick(0, 0, 2'b00, 1);
    tests++;
    if (bus.c2 !== 1'b1 || bus.credit !== 6'd20) begin
      fails++;
      $display("FAIL mid_pre c2 %b want 1 credit %0d want 20",
               bus.c2, bus.credit);
    end
    rst = 1'b1;
    tick(0, 0, 2'b00, 0);
    rst = 1'b0;
    tests++;
    if ({bus.c1, bus.c2, bus.busy} !== 3'b000 || bus.credit !== 6'd0) begin
      fails++;
      $display("FAIL mid_rst c1/c2/busy %b want 000 credit %0d want 0",
               {bus.c1, bus.c2, bus.busy}, bus.credit);
    end
  endtask

  task automatic test_cancel_priority();
    do_reset();
    tick(0, 1, 2'b00, 0);
    tick(0, 1, 2'b01, 1);
    tests++;
    if ({bus.z, bus.c2, bus.coin_rej} !== 3'b011
        || bus.credit !== 6'd10) begin
      fails++;
      $display("FAIL prio z/c2/rej %b want 011 credit %0d want 10",
               {bus.z, bus.c2, bus.coin_rej}, bus.credit);
    end
    tick(0, 0, 2'b00, 0);
    tests++;
    if ({bus.busy, bus.c2} !== 2'b00 || bus.credit !== 6'd0) begin
      fails++;
      $display("FAIL prio_end busy/c2 %b want 00 credit %0d want 0",
               {bus.busy, bus.c2}, bus.credit);
    end
  endtask

  initial begin
    bus.coin5  = 1'b0;
    bus.coin10 = 1'b0;
    bus.sel    = 2'b00;
    bus.cancel = 1'b0;
    test_reset();
    test_vend_exact();
    test_change();
    test_reject();
    test_max();
    test_cancel();
    test_insufficient();
    test_reset_mid_change();
    test_cancel_priority();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
